// File: rtl/optic_flow_pkg.sv
// Shared constants for the optic-flow colour custom instruction:
// RGB565 channel MSB positions and code/pixel widths.
package optic_flow_pkg;

  localparam int CODE_W  = 4;
  localparam int PIXEL_W = 16;

  localparam logic [PIXEL_W-1:0] RED_MSB   = 16'h8000;
  localparam logic [PIXEL_W-1:0] GREEN_MSB = 16'h0400;
  localparam logic [PIXEL_W-1:0] BLUE_MSB  = 16'h0010;

endpackage

// File: rtl/flow_code_to_rgb565.sv
// Maps one 4-bit optic-flow code to a mid-intensity RGB565 pixel.
// Each asserted channel lights only the MSB of its field.
module flow_code_to_rgb565
  import optic_flow_pkg::*;
(
  input  logic [CODE_W-1:0]  code_i,
  output logic [PIXEL_W-1:0] pixel_o
);

  logic red_s;
  logic green_s;
  logic blue_s;

  // Channel decode and pixel assembly
  always_comb begin
    red_s   = code_i[1] | code_i[2];
    green_s = code_i[0] | code_i[2];
    blue_s  = code_i[2] | code_i[3];
    pixel_o = (red_s   ? RED_MSB   : 16'h0000) |
              (green_s ? GREEN_MSB : 16'h0000) |
              (blue_s  ? BLUE_MSB  : 16'h0000);
  end

endmodule

// File: rtl/optic_flow_color_ci.sv
// Zero-latency CI: selects one byte of valueA by valueB[1:0] and expands its
// two flow codes into a pair of RGB565 pixels {hi, lo}.
module optic_flow_color_ci
  import optic_flow_pkg::*;
#(
  parameter logic [7:0] customInstructionId = 8'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  ciN,
  input  logic [31:0] valueA,
  input  logic [31:0] valueB,
  output logic        done,
  output logic [31:0] result
);

  logic                en_s;
  logic [7:0]          sel_s;
  logic [PIXEL_W-1:0]  pixel_hi_s;
  logic [PIXEL_W-1:0]  pixel_lo_s;

  // The clock exists only for bus uniformity and the upper index bits are ignored.
  logic unused_s;
  assign unused_s = ^{clock, valueB[31:2]};

  // Instruction decode and byte select
  always_comb begin
    en_s = start & (ciN == customInstructionId) & ~reset;
    case (valueB[1:0])
      2'd0:    sel_s = valueA[7:0];
      2'd1:    sel_s = valueA[15:8];
      2'd2:    sel_s = valueA[23:16];
      2'd3:    sel_s = valueA[31:24];
      default: sel_s = 8'h00;
    endcase
  end

  flow_code_to_rgb565 u_hi (
    .code_i  (sel_s[7:4]),
    .pixel_o (pixel_hi_s)
  );

  flow_code_to_rgb565 u_lo (
    .code_i  (sel_s[3:0]),
    .pixel_o (pixel_lo_s)
  );

  // Output gating; reset acts combinationally so outputs drop without a clock edge
  always_comb begin
    done   = en_s;
    result = en_s ? {pixel_hi_s, pixel_lo_s} : 32'h0000_0000;
  end

endmodule

// File: tb/tb_optic_flow_color_ci.sv
// Self-checking bench for optic_flow_color_ci: a colour-table model checked
// every negative clock edge, plus literal expectations for directed vectors.
module tb_optic_flow_color_ci;

  localparam logic [7:0] ID = 8'd30;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  ciN;
  logic [31:0] valueA;
  logic [31:0] valueB;
  logic        done;
  logic [31:0] result;

  int n_checks = 0;
  int n_fail   = 0;
  bit model_on = 1'b0;

  optic_flow_color_ci #(.customInstructionId(ID)) dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .ciN    (ciN),
    .valueA (valueA),
    .valueB (valueB),
    .done   (done),
    .result (result)
  );

  always #5 clock = ~clock;

  // Colour of a code, from the channel rules: red if code is 2,3,4..7 etc.
  function automatic logic [15:0] colour(input int n);
    int r, g, b;
    r = ((n / 2) % 2) | ((n / 4) % 2);
    g = (n % 2)       | ((n / 4) % 2);
    b = ((n / 4) % 2) | ((n / 8) % 2);
    return 16'(r * 32768 + g * 1024 + b * 16);
  endfunction

  function automatic logic [32:0] model(input logic rst, input logic st, input logic [7:0] cin,
                                        input logic [31:0] a, input logic [31:0] b);
    int byte_v;
    logic [31:0] word;
    if (rst || !st || cin != ID) return 33'h0;
    byte_v = int'((a >> (8 * (b % 4))) & 32'hFF);
    word = {colour(byte_v / 16), colour(byte_v % 16)};
    return {1'b1, word};
  endfunction

  // Continuous model comparison away from the active edge
  always @(negedge clock) begin
    if (model_on) begin
      logic [32:0] exp_v;
      exp_v = model(reset, start, ciN, valueA, valueB);
      n_checks++;
      if ({done, result} !== exp_v) begin
        n_fail++;
        $display("FAIL model: done=%b result=%h, expected done=%b result=%h (A=%h B=%h start=%b ciN=%0d)",
                 done, result, exp_v[32], exp_v[31:0], valueA, valueB, start, ciN);
      end
    end
  end

  task automatic apply(input logic st, input logic [7:0] cin, input logic [31:0] a, input logic [31:0] b);
    @(posedge clock);
    start  = st;
    ciN    = cin;
    valueA = a;
    valueB = b;
  endtask

  task automatic lit(input string name, input logic exp_done, input logic [31:0] exp_res);
    #1;
    n_checks++;
    if (done !== exp_done || result !== exp_res) begin
      n_fail++;
      $display("FAIL %s: done=%b result=%h, expected done=%b result=%h",
               name, done, result, exp_done, exp_res);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b1; ciN = ID; valueA = 32'hFFFF_FFFF; valueB = 32'h0;
    #1;
    lit("reset_state", 1'b0, 32'h0);
    apply(1'b0, ID, 32'h0, 32'h0);
    reset = 1'b0;
    model_on = 1'b1;

    // Idle and mismatch
    apply(1'b0, ID, 32'h0, 32'h0);                lit("idle", 1'b0, 32'h0);
    apply(1'b1, 8'd47, 32'h0000_00A5, 32'h0);     lit("mismatch", 1'b0, 32'h0);
    apply(1'b1, 8'd47, 32'hFFFF_FFFF, 32'h0);     lit("mismatch_ff", 1'b0, 32'h0);

    // Basic decode
    apply(1'b1, ID, 32'h0000_0001, 32'h0);        lit("dec_01", 1'b1, 32'h0000_0400);
    apply(1'b1, ID, 32'h0000_00A5, 32'h0);        lit("dec_a5", 1'b1, 32'h8010_8410);
    apply(1'b1, ID, 32'h0000_0042, 32'h0);        lit("dec_42", 1'b1, 32'h8410_8000);

    // Byte index, including ignored upper index bits
    apply(1'b1, ID, 32'h0001_1234, 32'd2);        lit("idx2_01", 1'b1, 32'h0000_0400);
    apply(1'b1, ID, 32'h00A5_1234, 32'd2);        lit("idx2_a5", 1'b1, 32'h8010_8410);
    apply(1'b1, ID, 32'h0042_1234, 32'd2);        lit("idx2_42", 1'b1, 32'h8410_8000);
    apply(1'b1, ID, 32'h0001_1234, 32'd6);        lit("idx6_01", 1'b1, 32'h0000_0400);
    apply(1'b1, ID, 32'h00A5_1234, 32'd6);        lit("idx6_a5", 1'b1, 32'h8010_8410);
    apply(1'b1, ID, 32'h0042_1234, 32'd6);        lit("idx6_42", 1'b1, 32'h8410_8000);
    apply(1'b1, ID, 32'hF000_0000, 32'd3);        lit("idx3_f0", 1'b1, 32'h8410_0000);
    apply(1'b1, ID, 32'h1234_5678, 32'd1);        lit("idx1_56", 1'b1, 32'h8410_8410);

    // Spot checks pinning the model's colour table
    apply(1'b1, ID, 32'h0000_0033, 32'h0);        lit("lut_33", 1'b1, 32'h8400_8400);
    apply(1'b1, ID, 32'h0000_0088, 32'h0);        lit("lut_88", 1'b1, 32'h0010_0010);
    apply(1'b1, ID, 32'h0000_00FF, 32'h0);        lit("lut_ff", 1'b1, 32'h8410_8410);

    // Exhaustive byte sweep, checked by the model process
    for (int i = 0; i < 256; i++) apply(1'b1, ID, 32'(i), 32'h0);

    // Reset mid-instruction acts without a clock edge
    apply(1'b1, ID, 32'h0000_00A5, 32'h0);
    reset = 1'b1;
    lit("reset_async", 1'b0, 32'h0);
    reset = 1'b0;
    lit("reset_release", 1'b1, 32'h8010_8410);

    // Start toggling every cycle with fresh operands
    for (int i = 0; i < 40; i++) apply(1'(i % 2), ID, $urandom, $urandom);

    apply(1'b0, ID, 32'h0, 32'h0);
    @(posedge clock);
    model_on = 1'b0;
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
